// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: arbitrates read/write requesters onto a strobe/ack register file with timeouts
module regfile_access_ctrl #(
   parameter int NUM_RD  = 2,
   parameter int REG_SZ  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_RD-1:0]   rd_req,
   input  logic [NUM_RD*5-1:0] rd_idx,
   output logic [NUM_RD-1:0]   rd_done,
   output logic [REG_SZ-1:0]   rd_data,
   input  logic                wr_req,
   input  logic [4:0]          wr_idx,
   input  logic [REG_SZ-1:0]   wr_data,
   output logic                wr_done,
   output logic                err,
   output logic                rf_re,
   output logic                rf_we,
   output logic [4:0]          rf_r_idx,
   output logic [4:0]          rf_w_idx,
   output logic [REG_SZ-1:0]   rf_din,
   input  logic [REG_SZ-1:0]   rf_dout,
   input  logic                rf_rack,
   input  logic                rf_wack
);
   localparam int GW = NUM_RD > 1 ? $clog2(NUM_RD) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_REL, WR_WAIT, WR_REL, DONE} state_t;
   state_t            state_q, state_d;
   logic [GW-1:0]     ptr_q, ptr_d, g_q, g_d, rr_g, cand;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              last_wr_q, last_wr_d, rr_hit, to;
   logic [NUM_RD-1:0] rd_done_d;
   logic [REG_SZ-1:0] rd_data_d, rf_din_d;
   logic              wr_done_d, err_d, rf_re_d, rf_we_d;
   logic [4:0]        rf_r_idx_d, rf_w_idx_d;
   logic [4:0]        idx_a [NUM_RD];
   for (genvar i = 0; i < NUM_RD; i++) begin : g_idx
      assign idx_a[i] = rd_idx[5*i +: 5];
   end
   // descending scan so the requester closest to the pointer wins
   always_comb begin
      rr_hit = 1'b0;
      rr_g   = ptr_q;
      cand   = '0;
      for (int k = NUM_RD - 1; k >= 0; k--) begin
         cand = GW'((int'(ptr_q) + k) % NUM_RD);
         if (rd_req[cand]) begin
            rr_hit = 1'b1;
            rr_g   = cand;
         end
      end
   end
   assign to = cnt_q == CW'(TIMEOUT - 1);
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      g_d        = g_q;
      last_wr_d  = last_wr_q;
      rd_done_d  = '0;
      wr_done_d  = 1'b0;
      err_d      = 1'b0;
      rd_data_d  = rd_data;
      rf_re_d    = rf_re;
      rf_we_d    = rf_we;
      rf_r_idx_d = rf_r_idx;
      rf_w_idx_d = rf_w_idx;
      rf_din_d   = rf_din;
      case (state_q)
         IDLE: begin
            if (wr_req && !(last_wr_q && rr_hit)) begin
               rf_w_idx_d = wr_idx;
               rf_din_d   = wr_data;
               rf_we_d    = 1'b1;
               state_d    = WR_WAIT;
            end else if (rr_hit) begin
               g_d        = rr_g;
               rf_r_idx_d = idx_a[rr_g];
               if (idx_a[rr_g] != 5'd0) begin
                  rf_re_d = 1'b1;
                  state_d = RD_WAIT;
               end else begin
                  rd_data_d        = '0;
                  rd_done_d[rr_g]  = 1'b1;
                  state_d          = DONE;
               end
            end
         end
         RD_WAIT: begin
            if (rf_rack) begin
               rd_data_d = rf_dout;
               rf_re_d   = 1'b0;
               state_d   = RD_REL;
            end else if (to) begin
               rf_re_d        = 1'b0;
               rd_data_d      = '0;
               rd_done_d[g_q] = 1'b1;
               err_d          = 1'b1;
               state_d        = DONE;
            end
         end
         RD_REL: begin
            if (!rf_rack || to) begin
               rd_done_d[g_q] = 1'b1;
               err_d          = rf_rack;
               rd_data_d      = rf_rack ? '0 : rd_data;
               state_d        = DONE;
            end
         end
         WR_WAIT: begin
            if (rf_wack) begin
               rf_we_d = 1'b0;
               state_d = WR_REL;
            end else if (to) begin
               rf_we_d   = 1'b0;
               wr_done_d = 1'b1;
               err_d     = 1'b1;
               state_d   = DONE;
            end
         end
         WR_REL: begin
            if (!rf_wack || to) begin
               wr_done_d = 1'b1;
               err_d     = rf_wack;
               state_d   = DONE;
            end
         end
         DONE: begin
            // wr_done is high here exactly when the finishing access was a write
            last_wr_d = wr_done;
            ptr_d     = wr_done ? ptr_q : (g_q == GW'(NUM_RD - 1) ? '0 : g_q + 1'b1);
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      cnt_d = (state_d != state_q || state_q == IDLE || state_q == DONE) ? '0 : cnt_q + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         g_q       <= '0;
         cnt_q     <= '0;
         last_wr_q <= 1'b0;
         rd_done   <= '0;
         rd_data   <= '0;
         wr_done   <= 1'b0;
         err       <= 1'b0;
         rf_re     <= 1'b0;
         rf_we     <= 1'b0;
         rf_r_idx  <= '0;
         rf_w_idx  <= '0;
         rf_din    <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         g_q       <= g_d;
         cnt_q     <= cnt_d;
         last_wr_q <= last_wr_d;
         rd_done   <= rd_done_d;
         rd_data   <= rd_data_d;
         wr_done   <= wr_done_d;
         err       <= err_d;
         rf_re     <= rf_re_d;
         rf_we     <= rf_we_d;
         rf_r_idx  <= rf_r_idx_d;
         rf_w_idx  <= rf_w_idx_d;
         rf_din    <= rf_din_d;
      end
   end
endmodule
